censor_mask_ctrl: RTL and testbench
===================================

CENSOR_MASK_CTRL -- requirements
Module: censor_mask_ctrl

Interface
REQ-001 Parameter: WORD_LEN, default 4, legal 2..8; length in chars of the censored word and of the look-ahead window.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 aresetn  input  1  reset, synchronous, active-low.
REQ-004 cfg_word  input  8*WORD_LEN  censored word; byte 0 (LSBs) = first char.
REQ-005 cfg_we  input  1  load cfg_word into internal word register.
REQ-006 in_valid / in_char  input  1 / 8  upstream char stream; 8'h00 = end-of-string terminator.
REQ-007 in_ready  output  1  char accepted on cycle where in_valid && in_ready.
REQ-008 out_valid / out_char / out_mask  output  1 / 8 / 1  char and mask bit to the char-select datapath.
REQ-009 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 match_count  output  16  number of matches since reset, saturating at 16'hFFFF.

Function
REQ-012 Internal: window of WORD_LEN entries {char, mask}, ordered oldest..newest; count 0..WORD_LEN; output register {out_valid, out_char, out_mask}; word register.
REQ-013 States: IDLE (count=0), FILL (0<count<WORD_LEN), STREAM (count=WORD_LEN), DRAIN.
REQ-014 out_free = !out_valid || out_ready.
REQ-015 in_ready = 1 in IDLE/FILL when out_free; 1 in STREAM only when out_free; 0 in DRAIN.
REQ-016 Accepted non-zero char appends as newest with mask 0; in STREAM, the oldest entry moves to the output register in the same cycle.
REQ-017 Match: on accept of a non-zero char with resulting window full, compare the post-insertion window to the word register byte-for-byte; on equality, set mask of all WORD_LEN entries (OR with existing masks, so overlapping matches stay masked) and increment match_count.
REQ-018 Transitions: IDLE->FILL on non-zero accept; FILL->STREAM when count reaches WORD_LEN; IDLE/FILL/STREAM->DRAIN on accept of 8'h00.
REQ-019 Terminator is never stored in the window and never compared.
REQ-020 DRAIN: each cycle with out_free, the oldest entry moves to the output register; when the window is empty, 8'h00 with out_mask=0 is loaded; on the cycle that terminator is accepted downstream -> IDLE.
REQ-021 Output register holds out_char/out_mask stable while out_valid && !out_ready; out_valid drops after acceptance when nothing new is loaded.
REQ-022 Latency: a char is presented WORD_LEN accepts after entry (one cycle after the accept that pushes it out), or during DRAIN.
REQ-023 cfg_we is honoured only in IDLE; ignored in every other state, with no side effect.
REQ-024 Reset word = all zeros; since 8'h00 is never stored, no match is possible until a word is loaded.
REQ-025 in_valid with in_ready=0: no state change; upstream holds the char.

Reset
REQ-026 Synchronous reset (aresetn=0 at a clk edge): state=IDLE, count=0, window cleared, out_valid=0, out_char=8'h00, out_mask=0, in_ready=0 during reset, busy=0, match_count=0, word register=0.
REQ-027 Reset mid-operation discards all buffered chars and any pending terminator; out_valid=0 from the first edge with aresetn=0.

Configuration
REQ-028 Macro CENSOR_CASE_FOLD_EN defined: both operands of the match compare have 'A'..'Z' mapped to 'a'..'z'; stored and emitted chars are unchanged.
REQ-029 Macro not defined: the compare is exact 8-bit equality.

Verification (WORD_LEN=4)
REQ-030 Load "dang" in IDLE; stream "xdangy",00 with out_ready=1 -> out x,d,a,n,g,y,00; masks 0,1,1,1,1,0,0; match_count=1; busy=0 after the terminator is accepted.
REQ-031 Window full with output valid, out_ready=0 for 5 cycles -> in_ready=0, out_char/out_mask stable; on release, the stream resumes with no loss or duplication.
REQ-032 Word "aaaa"; stream "aaaaab",00 -> first five chars masked, b unmasked; match_count=2.
REQ-033 cfg_we with "zzzz" while in FILL -> ignored; the earlier word still matches.
REQ-034 aresetn=0 for one cycle mid-STREAM -> out_valid=0, count=0, match_count=0, word cleared; the following "dang" does not match.
REQ-035 Word "dang", stream "DaNg",00 -> masks 1,1,1,1 with CENSOR_CASE_FOLD_EN; 0,0,0,0 without; emitted chars unchanged in both builds.

Source files
------------

// File: rtl/censor_mask_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// censor_mask_ctrl: WORD_LEN-deep look-ahead window that flags every char of a
// censored word. Optional macro CENSOR_CASE_FOLD_EN folds A-Z for the compare.
// Revision: 1.0
// ---------------------------------------------------------------------------
module censor_mask_ctrl #(
  parameter int WORD_LEN = 4
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [8*WORD_LEN-1:0] cfg_word,
  input  logic                  cfg_we,
  input  logic                  in_valid,
  input  logic [7:0]            in_char,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [7:0]            out_char,
  output logic                  out_mask,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [15:0]           match_count
);

  localparam int CW = $clog2(WORD_LEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [7:0]              win_char     [WORD_LEN];
  logic [WORD_LEN-1:0]     win_mask;
  logic [CW-1:0]           count;
  logic [8*WORD_LEN-1:0]   word;
  logic                    term_sent;

  logic                    out_free, acc, acc_data, acc_term, full_after, match, term_done;
  logic [7:0]              shifted_char [WORD_LEN];
  logic [WORD_LEN-1:0]     shifted_mask;
  logic [7:0]              popped_char  [WORD_LEN];
  logic [7:0]              post_char    [WORD_LEN];
  logic [WORD_LEN-1:0]     post_mask;

  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef CENSOR_CASE_FOLD_EN
    fold = (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
`else
    fold = c;
`endif
  endfunction

  // Shifted view = window after the oldest leaves and in_char enters as newest.
  for (genvar g = 0; g < WORD_LEN; g++) begin : g_win
    if (g < WORD_LEN - 1) begin : g_mid
      assign shifted_char[g] = win_char[g+1];
      assign shifted_mask[g] = win_mask[g+1];
      assign popped_char[g]  = win_char[g+1];
    end else begin : g_last
      assign shifted_char[g] = in_char;
      assign shifted_mask[g] = 1'b0;
      assign popped_char[g]  = 8'h00;
    end
  end

  always_comb begin
    out_free   = !out_valid || out_ready;
    in_ready   = aresetn && out_free && (state != DRAIN);
    acc        = in_valid && in_ready;
    acc_term   = acc && (in_char == 8'h00);
    acc_data   = acc && (in_char != 8'h00);
    full_after = (state == STREAM) || ((state == FILL) && (count == CW'(WORD_LEN - 1)));
    term_done  = (state == DRAIN) && term_sent && out_valid && out_ready;
    busy       = (state != IDLE);
    post_mask  = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (state == STREAM) begin
        post_char[i] = shifted_char[i];
        post_mask[i] = shifted_mask[i];
      end else if (CW'(i) == count) begin
        post_char[i] = in_char;
        post_mask[i] = 1'b0;
      end else begin
        post_char[i] = win_char[i];
        post_mask[i] = win_mask[i];
      end
    end
    match = acc_data && full_after;
    for (int i = 0; i < WORD_LEN; i++) begin
      if (fold(post_char[i]) != fold(word[8*i +: 8])) match = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc_term) state_nxt = DRAIN;
               else if (acc_data) state_nxt = FILL;
      FILL:    if (acc_term) state_nxt = DRAIN;
               else if (acc_data && count == CW'(WORD_LEN - 1)) state_nxt = STREAM;
      STREAM:  if (acc_term) state_nxt = DRAIN;
      DRAIN:   if (term_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      for (int i = 0; i < WORD_LEN; i++) win_char[i] <= 8'h00;
      win_mask    <= '0;
      count       <= '0;
      word        <= '0;
      out_valid   <= 1'b0;
      out_char    <= 8'h00;
      out_mask    <= 1'b0;
      term_sent   <= 1'b0;
      match_count <= '0;
    end else begin
      if (state == IDLE && cfg_we) word <= cfg_word;
      if (match && match_count != 16'hFFFF) match_count <= match_count + 16'd1;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (acc_data) begin
        for (int i = 0; i < WORD_LEN; i++) win_char[i] <= post_char[i];
        // Overlapping matches: a new match sets all masks, never clears older ones.
        win_mask <= match ? '1 : post_mask;
        if (state == STREAM) begin
          out_valid <= 1'b1;
          out_char  <= win_char[0];
          out_mask  <= win_mask[0];
        end else begin
          count <= count + CW'(1);
        end
      end

      if (state == DRAIN) begin
        if (term_done) begin
          term_sent <= 1'b0;
        end else if (out_free) begin
          if (count != '0) begin
            for (int i = 0; i < WORD_LEN; i++) win_char[i] <= popped_char[i];
            win_mask  <= win_mask >> 1;
            count     <= count - CW'(1);
            out_valid <= 1'b1;
            out_char  <= win_char[0];
            out_mask  <= win_mask[0];
          end else if (!term_sent) begin
            out_valid <= 1'b1;
            out_char  <= 8'h00;
            out_mask  <= 1'b0;
            term_sent <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_censor_mask_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_censor_mask_ctrl: table vectors, directed corner sequences and random
// strings checked against a substring-level reference model. Revision: 1.0
// ---------------------------------------------------------------------------
module tb_censor_mask_ctrl;
  localparam int WL = 4;

  logic            clk = 1'b0;
  logic            aresetn = 1'b0;
  logic [8*WL-1:0] cfg_word = '0;
  logic            cfg_we = 1'b0;
  logic            in_valid = 1'b0;
  logic [7:0]      in_char = 8'h00;
  logic            in_ready;
  logic            out_valid;
  logic [7:0]      out_char;
  logic            out_mask;
  logic            out_ready = 1'b1;
  logic            busy;
  logic [15:0]     match_count;

  censor_mask_ctrl #(.WORD_LEN(WL)) dut (
    .clk(clk), .aresetn(aresetn), .cfg_word(cfg_word), .cfg_we(cfg_we),
    .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .out_valid(out_valid), .out_char(out_char), .out_mask(out_mask),
    .out_ready(out_ready), .busy(busy), .match_count(match_count)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] word;   // literal, first char in MSBs
    logic [63:0] text;   // literal, last char in LSBs
    logic [3:0]  len;
    logic [8:0]  mask;   // output j (terminator included) -> mask[len-j]
    logic [7:0]  nm;
  } vec_t;

  int         n_assert = 0;
  int         n_fail = 0;
  int         model_mc = 0;
  bit         rand_rdy = 1'b0;
  logic [7:0] got_c[$];
  logic       got_m[$];
  logic [7:0] exp_c[$];
  logic       exp_m[$];
  vec_t       tbl[7];

  always @(negedge clk)
    if (aresetn && out_valid && out_ready) begin
      got_c.push_back(out_char);
      got_m.push_back(out_mask);
    end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] fc(input logic [7:0] c);
`ifdef CENSOR_CASE_FOLD_EN
    return (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
`else
    return c;
`endif
  endfunction

  function automatic logic [31:0] wpk(input logic [31:0] lit);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = lit[8*(3-i) +: 8];
    return r;
  endfunction

  function automatic bq_t from_packed(input logic [63:0] t, input int len);
    bq_t q;
    for (int j = 0; j < len; j++) q.push_back(t[8*(len-1-j) +: 8]);
    return q;
  endfunction

  // Every length-WL substring equal to the word marks its chars and counts once.
  task automatic model(input logic [31:0] w, input bq_t t);
    logic m[$];
    bit   eq;
    foreach (t[j]) m.push_back(1'b0);
    for (int k = 0; k + WL <= t.size(); k++) begin
      eq = 1'b1;
      for (int i = 0; i < WL; i++) if (fc(t[k+i]) != fc(w[8*i +: 8])) eq = 1'b0;
      if (eq) begin
        model_mc++;
        for (int i = 0; i < WL; i++) m[k+i] = 1'b1;
      end
    end
    foreach (t[j]) begin
      exp_c.push_back(t[j]);
      exp_m.push_back(m[j]);
    end
    exp_c.push_back(8'h00);
    exp_m.push_back(1'b0);
  endtask

  task automatic load_word(input logic [31:0] w);
    cfg_word = w; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input bq_t t, input bit term, input int gap);
    bq_t s;
    bit  ok;
    s = t;
    if (term) s.push_back(8'h00);
    foreach (s[j]) begin
      in_valid = 1'b1; in_char = s[j]; ok = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
        @(negedge clk); ok = in_ready;
        tick();
      end
      in_valid = 1'b0;
      if (!ok) chk("in_accept_timeout", 32'd0, 32'd1);
      if (gap > 0) repeat ($urandom_range(0, gap)) tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 600 && busy; k++) tick();
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, got_c.size(), exp_c.size());
    for (int j = 0; j < exp_c.size() && j < got_c.size(); j++) begin
      chk($sformatf("%s_char%0d", tag, j), got_c[j], exp_c[j]);
      chk($sformatf("%s_mask%0d", tag, j), got_m[j], exp_m[j]);
    end
    got_c.delete(); got_m.delete(); exp_c.delete(); exp_m.delete();
  endtask

  task automatic do_reset();
    aresetn = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 0);
    chk("rst_out_mask", out_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_match_count", match_count, 0);
    aresetn = 1'b1;
    tick();
    got_c.delete(); got_m.delete(); exp_c.delete(); exp_m.delete();
    model_mc = 0;
  endtask

  initial begin
    bq_t         t;
    logic [31:0] w;
    int          mc0;

    tbl[0] = '{word: "dang", text: "xdangy",   len: 4'd6, mask: 9'b000111100, nm: 8'd1};
    tbl[1] = '{word: "aaaa", text: "aaaaab",   len: 4'd6, mask: 9'b001111100, nm: 8'd2};
`ifdef CENSOR_CASE_FOLD_EN
    tbl[2] = '{word: "dang", text: "DaNg",     len: 4'd4, mask: 9'b000011110, nm: 8'd1};
`else
    tbl[2] = '{word: "dang", text: "DaNg",     len: 4'd4, mask: 9'b000000000, nm: 8'd0};
`endif
    tbl[3] = '{word: "dang", text: "dangdang", len: 4'd8, mask: 9'b111111110, nm: 8'd2};
    tbl[4] = '{word: "dang", text: "dan",      len: 4'd3, mask: 9'b000000000, nm: 8'd0};
    tbl[5] = '{word: "dang", text: 64'd0,      len: 4'd0, mask: 9'b000000000, nm: 8'd0};
    tbl[6] = '{word: "abab", text: "ababab",   len: 4'd6, mask: 9'b001111110, nm: 8'd2};

    do_reset();

    // Table vectors, downstream always ready.
    for (int v = 0; v < 7; v++) begin
      load_word(wpk(tbl[v].word));
      mc0 = int'(match_count);
      t = from_packed(tbl[v].text, int'(tbl[v].len));
      foreach (t[j]) begin
        exp_c.push_back(t[j]);
        exp_m.push_back(tbl[v].mask[int'(tbl[v].len) - j]);
      end
      exp_c.push_back(8'h00);
      exp_m.push_back(tbl[v].mask[0]);
      send(t, 1'b1, 0);
      wait_idle($sformatf("tbl%0d", v));
      check_stream($sformatf("tbl%0d", v));
      chk($sformatf("tbl%0d_mcount", v), 32'(int'(match_count) - mc0), 32'(tbl[v].nm));
    end

    // Backpressure with a full window and a held output.
    do_reset();
    out_ready = 1'b0;
    load_word(wpk("dang"));
    send(from_packed("abcde", 5), 1'b0, 0);
    in_valid = 1'b1; in_char = "f";
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_char", out_char, "a");
      chk("bp_out_mask", out_mask, 0);
    end
    out_ready = 1'b1;
    send(from_packed("fg", 2), 1'b1, 0);
    wait_idle("bp");
    model(wpk("dang"), from_packed("abcdefg", 7));
    check_stream("bp");

    // Word write during FILL must be ignored.
    do_reset();
    load_word(wpk("dang"));
    send(from_packed("da", 2), 1'b0, 0);
    chk("cfgfill_busy", busy, 1);
    load_word(wpk("zzzz"));
    send(from_packed("ng", 2), 1'b1, 0);
    wait_idle("cfgfill");
    model(wpk("dang"), from_packed("dang", 4));
    check_stream("cfgfill");
    chk("cfgfill_mcount", match_count, model_mc);

    // Reset in the middle of STREAM clears buffered chars and the word.
    do_reset();
    load_word(wpk("dang"));
    send(from_packed("dangwv", 6), 1'b0, 0);
    chk("midrst_pre_mcount", match_count, 1);
    do_reset();
    send(from_packed("dang", 4), 1'b1, 0);
    wait_idle("midrst");
    model(32'd0, from_packed("dang", 4));
    check_stream("midrst");
    chk("midrst_mcount", match_count, 0);

    // Random strings with random downstream stalls and upstream gaps.
    do_reset();
    rand_rdy = 1'b1;
    for (int n = 0; n < 25; n++) begin
      int len;
      int pos;
      w = '0;
      for (int i = 0; i < WL; i++) w[8*i +: 8] = ($urandom_range(0, 1) != 0) ? "a" : "b";
      t.delete();
      len = $urandom_range(0, 12);
      for (int j = 0; j < len; j++)
        case ($urandom_range(0, 3))
          0: t.push_back("a");
          1: t.push_back("b");
          2: t.push_back("A");
          default: t.push_back("B");
        endcase
      if (len >= WL && $urandom_range(0, 1) != 0) begin
        pos = $urandom_range(0, len - WL);
        for (int i = 0; i < WL; i++) t[pos+i] = w[8*i +: 8];
      end
      load_word(w);
      model(w, t);
      send(t, 1'b1, 3);
      wait_idle($sformatf("rnd%0d", n));
      check_stream($sformatf("rnd%0d", n));
    end
    chk("rnd_mcount", match_count, model_mc);
    rand_rdy = 1'b0;
    out_ready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
